// File: rtl/mem_pkg.sv
// Shared types for the MEM response stage: load opcodes, result entries,
// and the datapath-width legality check.
package mem_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [3:0] {
        LOP_NONE = 4'd0,
        LB       = 4'd1,
        LBU      = 4'd2,
        LH       = 4'd3,
        LHU      = 4'd4,
        LW       = 4'd5,
        LWU      = 4'd6,
        LD       = 4'd7,
        LWL      = 4'd8,
        LWR      = 4'd9
    } load_op_t;

    typedef struct packed {
        logic [31:0]      pc;
        logic             ex;
        logic             gr_we;
        logic [4:0]       dest;
        logic [MAX_W-1:0] result;
    } entry_t;

    function automatic bit data_w_ok(input int w);
        return (w == 32) || (w == 64);
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: selects byte/half/word/dword from the DCache beat
// and extends it; LWL/LWR merge the selected word with the old rt.
module load_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFS_W  = $clog2(DATA_W / 8)
) (
    input  load_op_t          op,
    input  logic [OFS_W-1:0]  ofs,
    input  logic [DATA_W-1:0] rdata,
    input  logic [31:0]       rt,
    output logic [DATA_W-1:0] result
);

    logic [OFS_W-1:0] wofs;
    logic [7:0]       b;
    logic [15:0]      h;
    logic [31:0]      w;
    logic [31:0]      merged;

    always_comb begin
        wofs = ofs & ~OFS_W'(3);
        b    = rdata[{ofs, 3'b000} +: 8];
        h    = ofs[0] ? 16'h0 : rdata[{ofs[OFS_W-1:1], 4'b0000} +: 16];
        w    = rdata[{wofs, 3'b000} +: 32];

        merged = w;
        if (op == LWR) begin
            unique case (ofs[1:0])
                2'd0: merged = w;
                2'd1: merged = {rt[31:24], w[31:8]};
                2'd2: merged = {rt[31:16], w[31:16]};
                2'd3: merged = {rt[31:8], w[31:24]};
            endcase
        end else begin
            unique case (ofs[1:0])
                2'd0: merged = {w[7:0], rt[23:0]};
                2'd1: merged = {w[15:0], rt[15:0]};
                2'd2: merged = {w[23:0], rt[7:0]};
                2'd3: merged = w;
            endcase
        end

        result = '0;
        unique case (op)
            LB:       result = DATA_W'($signed(b));
            LBU:      result = DATA_W'(b);
            LH:       result = DATA_W'($signed(h));
            LHU:      result = DATA_W'(h);
            LW:       result = DATA_W'($signed(w));
            LWU:      result = DATA_W'(w);
            LD:       result = rdata;
            LWL, LWR: result = DATA_W'($signed(merged));
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/mem_resp_stage.sv
// MEM response stage: one working slot waiting on DCache data, feeding a
// DEPTH-entry result FIFO toward WB, with flush discard and forwarding.
module mem_resp_stage
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int OFS_W  = $clog2(DATA_W / 8)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        m1s_to_ms_valid,
    output logic                        ms_allowin,
    input  logic [31:0]                 in_pc,
    input  logic                        in_ex,
    input  logic                        in_gr_we,
    input  logic [4:0]                  in_dest,
    input  logic [3:0]                  in_mem_op,
    input  logic [DATA_W-1:0]           in_alu_result,
    input  logic [DATA_W-1:0]           in_rt_value,
    input  logic                        in_mfc0,
    input  logic [31:0]                 in_cp0_data,
    input  logic                        data_rvalid,
    input  logic [DATA_W-1:0]           data_rdata,
    input  logic                        ws_allowin,
    output logic                        ms_to_ws_valid,
    output logic [31:0]                 out_pc,
    output logic                        out_ex,
    output logic                        out_gr_we,
    output logic [4:0]                  out_dest,
    output logic [DATA_W-1:0]           out_result,
    output logic [4:0]                  pend_dest,
    output logic [DEPTH:0]              fwd_valid,
    output logic [5*(DEPTH+1)-1:0]      fwd_dest,
    output logic [DATA_W*(DEPTH+1)-1:0] fwd_result,
    output logic                        resp_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    if (!data_w_ok(DATA_W) || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
        $error("mem_resp_stage: DATA_W must be 32/64, DEPTH a power of two >= 2");
    end

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_READY} w_state_t;

    w_state_t          w_state;
    entry_t            w_q;
    load_op_t          w_op;
    logic [31:0]       w_rt;
    entry_t            fifo [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, idx;
    logic [CNT_W-1:0]  count;
    logic              discard;

    logic              is_idle, is_wait, is_ready;
    logic              rv_hit, pop, push, accept, is_load;
    logic [DATA_W-1:0] acc_result, align_res;
    entry_t            push_e, head;
    logic              unused_bits;

    assign is_idle  = (w_state == W_IDLE);
    assign is_wait  = (w_state == W_WAIT);
    assign is_ready = (w_state == W_READY);

    assign rv_hit         = data_rvalid & is_wait & ~discard;
    assign ms_to_ws_valid = (count != '0);
    assign pop            = ms_to_ws_valid & ws_allowin;
    assign push           = (is_ready | rv_hit) & ((count < CNT_W'(DEPTH)) | pop);
    assign ms_allowin     = (is_idle | push) & ~discard;
    assign accept         = m1s_to_ms_valid & ms_allowin & ~flush;
    assign is_load        = (load_op_t'(in_mem_op) != LOP_NONE) & ~in_ex;

    assign acc_result = (in_mfc0 & ~in_ex) ? DATA_W'($signed(in_cp0_data))
                                           : in_alu_result;

    // While waiting, the stored result still holds the effective address.
    load_align #(.DATA_W(DATA_W), .OFS_W(OFS_W)) u_align (
        .op     (w_op),
        .ofs    (w_q.result[OFS_W-1:0]),
        .rdata  (data_rdata),
        .rt     (w_rt),
        .result (align_res)
    );

    always_comb begin
        push_e = w_q;
        if (is_wait) push_e.result = MAX_W'(align_res);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
            w_q     <= '0;
            w_op    <= LOP_NONE;
            w_rt    <= '0;
        end else if (flush) begin
            w_state <= W_IDLE;
        end else if (accept) begin
            w_state <= is_load ? W_WAIT : W_READY;
            w_q     <= '{pc: in_pc, ex: in_ex, gr_we: in_gr_we,
                         dest: in_dest, result: MAX_W'(acc_result)};
            w_op    <= load_op_t'(in_mem_op);
            w_rt    <= in_rt_value[31:0];
        end else if (push) begin
            w_state <= W_IDLE;
        end else if (rv_hit) begin
            w_state      <= W_READY;
            w_q.result   <= MAX_W'(align_res);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= push_e;
                wr_ptr       <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // A response already in flight at flush time must not land in a new load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            discard  <= 1'b0;
            resp_err <= 1'b0;
        end else begin
            if (data_rvalid & discard)
                discard <= 1'b0;
            else if (flush & is_wait & ~data_rvalid)
                discard <= 1'b1;
            if (data_rvalid & ~is_wait & ~discard)
                resp_err <= 1'b1;
        end
    end

    assign head       = fifo[rd_ptr];
    assign out_pc     = ms_to_ws_valid ? head.pc : '0;
    assign out_ex     = ms_to_ws_valid & head.ex;
    assign out_gr_we  = ms_to_ws_valid & head.gr_we;
    assign out_dest   = ms_to_ws_valid ? head.dest : '0;
    assign out_result = ms_to_ws_valid ? head.result[DATA_W-1:0] : '0;
    assign pend_dest  = (is_wait & w_q.gr_we) ? w_q.dest : '0;

    always_comb begin
        fwd_valid  = '0;
        fwd_dest   = '0;
        fwd_result = '0;
        idx        = '0;
        if (is_ready) begin
            fwd_valid[0]            = 1'b1;
            fwd_dest[4:0]           = w_q.gr_we ? w_q.dest : 5'd0;
            fwd_result[DATA_W-1:0]  = w_q.result[DATA_W-1:0];
        end
        for (int i = 1; i <= DEPTH; i++) begin
            if (CNT_W'(i) <= count) begin
                idx                            = wr_ptr - PTR_W'(i);
                fwd_valid[i]                   = 1'b1;
                fwd_dest[i*5 +: 5]             = fifo[idx].gr_we ? fifo[idx].dest : 5'd0;
                fwd_result[i*DATA_W +: DATA_W] = fifo[idx].result[DATA_W-1:0];
            end
        end
    end

    assign unused_bits = ^{head.result, w_q.result, in_rt_value};

endmodule

// File: tb/tb_mem_resp_stage.sv
// Directed bench for mem_resp_stage at DATA_W=64, DEPTH=2, with a WB-side
// scoreboard of expected results.
module tb_mem_resp_stage;
    import mem_pkg::*;

    localparam int DW = 64;
    localparam int DP = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            m1s_to_ms_valid;
    logic            ms_allowin;
    logic [31:0]     in_pc;
    logic            in_ex;
    logic            in_gr_we;
    logic [4:0]      in_dest;
    logic [3:0]      in_mem_op;
    logic [DW-1:0]   in_alu_result;
    logic [DW-1:0]   in_rt_value;
    logic            in_mfc0;
    logic [31:0]     in_cp0_data;
    logic            data_rvalid;
    logic [DW-1:0]   data_rdata;
    logic            ws_allowin;
    logic            ms_to_ws_valid;
    logic [31:0]     out_pc;
    logic            out_ex;
    logic            out_gr_we;
    logic [4:0]      out_dest;
    logic [DW-1:0]   out_result;
    logic [4:0]      pend_dest;
    logic [DP:0]     fwd_valid;
    logic [5*(DP+1)-1:0]  fwd_dest;
    logic [DW*(DP+1)-1:0] fwd_result;
    logic            resp_err;

    mem_resp_stage #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .m1s_to_ms_valid(m1s_to_ms_valid), .ms_allowin(ms_allowin),
        .in_pc(in_pc), .in_ex(in_ex), .in_gr_we(in_gr_we), .in_dest(in_dest),
        .in_mem_op(in_mem_op), .in_alu_result(in_alu_result),
        .in_rt_value(in_rt_value), .in_mfc0(in_mfc0), .in_cp0_data(in_cp0_data),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
        .out_pc(out_pc), .out_ex(out_ex), .out_gr_we(out_gr_we),
        .out_dest(out_dest), .out_result(out_result), .pend_dest(pend_dest),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_result(fwd_result),
        .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        ex;
        logic        we;
        logic [4:0]  dest;
        logic [63:0] result;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction and holds it until the stage takes it.
    task automatic send(input logic [31:0] pc, input logic [3:0] op,
                        input logic [63:0] alu, input logic [63:0] rt,
                        input logic [4:0] dest, input logic we, input logic ex,
                        input logic mfc0, input logic [31:0] cp0,
                        input logic [63:0] exp, input bit track);
        logic ok;
        exp_t e;
        m1s_to_ms_valid = 1'b1;
        in_pc = pc; in_mem_op = op; in_alu_result = alu; in_rt_value = rt;
        in_dest = dest; in_gr_we = we; in_ex = ex; in_mfc0 = mfc0;
        in_cp0_data = cp0;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            ok = ms_allowin;
            tick();
        end
        m1s_to_ms_valid = 1'b0;
        chk("accepted", ok, 1);
        if (ok && track) begin
            e.pc = pc; e.ex = ex; e.we = we; e.dest = dest; e.result = exp;
            sb.push_back(e);
        end
    endtask

    task automatic resp(input logic [63:0] d);
        data_rvalid = 1'b1;
        data_rdata  = d;
        tick();
        data_rvalid = 1'b0;
    endtask

    task automatic load_case(input logic [31:0] pc, input logic [3:0] op,
                             input logic [63:0] alu, input logic [63:0] rt,
                             input logic [63:0] rd, input logic [63:0] exp);
        send(pc, op, alu, rt, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, exp, 1'b1);
        resp(rd);
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && sb.size() != 0; n++) tick();
        chk("drain", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL wb_unexpected: got pc %h required no output", out_pc);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_pc", out_pc, e.pc);
                chk("wb_ex", out_ex, e.ex);
                chk("wb_gr_we", out_gr_we, e.we);
                chk("wb_dest", out_dest, e.dest);
                chk("wb_result", out_result, e.result);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; flush = 1'b0; m1s_to_ms_valid = 1'b0;
        in_pc = '0; in_ex = 1'b0; in_gr_we = 1'b0; in_dest = '0;
        in_mem_op = LOP_NONE; in_alu_result = '0; in_rt_value = '0;
        in_mfc0 = 1'b0; in_cp0_data = '0; data_rvalid = 1'b0;
        data_rdata = '0; ws_allowin = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", ms_to_ws_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_fwd_valid", fwd_valid, 0);
        chk("rst_pend", pend_dest, 0);
        chk("rst_resp_err", resp_err, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_allowin", ms_allowin, 1);
        tick();

        // Load latency: pending dest while waiting, head right after rvalid edge
        send(32'h100, LB, 64'h1003, 64'h0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0,
             64'hFFFF_FFFF_FFFF_FF80, 1'b1);
        @(negedge clk);
        chk("ld_pend_dest", pend_dest, 5);
        chk("ld_no_head", ms_to_ws_valid, 0);
        tick();
        resp(64'h80FF_0000);
        @(negedge clk);
        chk("ld_head", ms_to_ws_valid, 1);
        tick();

        // Alignment table
        load_case(32'h104, LBU, 64'h1003, 64'h0, 64'h80FF_0000, 64'h80);
        load_case(32'h108, LWL, 64'h1001, 64'hAABB_CCDD, 64'h1122_3344, 64'h3344_CCDD);
        load_case(32'h10C, LWR, 64'h1002, 64'hAABB_CCDD, 64'h1122_3344,
                  64'hFFFF_FFFF_AABB_1122);
        load_case(32'h110, LWL, 64'h1005, 64'hAABB_CCDD, 64'h1122_3344_0000_0000,
                  64'h3344_CCDD);
        load_case(32'h114, LD, 64'h1000, 64'h0, 64'h0123_4567_89AB_CDEF,
                  64'h0123_4567_89AB_CDEF);
        load_case(32'h118, LWU, 64'h1004, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567);
        load_case(32'h11C, LW, 64'h1000, 64'h0, 64'h0123_4567_89AB_CDEF,
                  64'hFFFF_FFFF_89AB_CDEF);
        load_case(32'h120, LH, 64'h1002, 64'h0, 64'h0123_4567_89AB_CDEF,
                  64'hFFFF_FFFF_FFFF_89AB);
        load_case(32'h124, LH, 64'h1001, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0);
        load_case(32'h128, LHU, 64'h1006, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0123);
        load_case(32'h12C, LB, 64'h1007, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h01);
        drain();

        // Non-load latency, exception-carrying load, mfc0
        send(32'h500, LOP_NONE, 64'h1234, 64'h0, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0,
             64'h1234, 1'b1);
        @(negedge clk);
        chk("nl_not_yet", ms_to_ws_valid, 0);
        chk("nl_fwd0_valid", fwd_valid[0], 1);
        chk("nl_fwd0_result", fwd_result[63:0], 64'h1234);
        tick();
        @(negedge clk);
        chk("nl_latency", ms_to_ws_valid, 1);
        tick();
        send(32'h600, LW, 64'hABC, 64'h0, 5'd8, 1'b1, 1'b1, 1'b0, 32'h0, 64'hABC, 1'b1);
        send(32'h604, LOP_NONE, 64'h0, 64'h0, 5'd4, 1'b1, 1'b0, 1'b1, 32'h8000_0001,
             64'hFFFF_FFFF_8000_0001, 1'b1);
        drain();

        // Backpressure: FIFO full plus READY slot, then release in order
        ws_allowin = 1'b0;
        send(32'h200, LOP_NONE, 64'hA0, 64'h0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0, 64'hA0, 1'b1);
        send(32'h204, LOP_NONE, 64'hA4, 64'h0, 5'd2, 1'b0, 1'b0, 1'b0, 32'h0, 64'hA4, 1'b1);
        send(32'h208, LOP_NONE, 64'hA8, 64'h0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 64'hA8, 1'b1);
        @(negedge clk);
        chk("bp_allowin", ms_allowin, 0);
        chk("bp_fwd_valid", fwd_valid, 3'b111);
        chk("bp_fwd_dest", fwd_dest, {5'd1, 5'd0, 5'd3});
        chk("bp_fwd0_result", fwd_result[63:0], 64'hA8);
        chk("bp_fwd2_result", fwd_result[191:128], 64'hA0);
        chk("bp_head_pc", out_pc, 32'h200);
        tick();
        ws_allowin = 1'b1;
        send(32'h20C, LOP_NONE, 64'hAC, 64'h0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0, 64'hAC, 1'b1);
        drain();

        // Load response arrives while FIFO is full and popping
        ws_allowin = 1'b0;
        send(32'h300, LOP_NONE, 64'hB0, 64'h0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0, 64'hB0, 1'b1);
        send(32'h304, LOP_NONE, 64'hB4, 64'h0, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0, 64'hB4, 1'b1);
        send(32'h308, LW, 64'h2004, 64'h0, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0,
             64'h0123_4567, 1'b1);
        ws_allowin  = 1'b1;
        data_rvalid = 1'b1;
        data_rdata  = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        chk("fp_allowin", ms_allowin, 1);
        tick();
        data_rvalid = 1'b0;
        @(negedge clk);
        chk("fp_fwd_valid", fwd_valid, 3'b110);
        chk("fp_fwd_dest", fwd_dest, {5'd2, 5'd6, 5'd0});
        chk("fp_head_pc", out_pc, 32'h304);
        tick();
        drain();

        // Flush with a load in flight and a non-empty FIFO
        ws_allowin = 1'b0;
        send(32'h3F0, LOP_NONE, 64'hC0, 64'h0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
        send(32'h400, LW, 64'h3000, 64'h0, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("fl_empty", ms_to_ws_valid, 0);
        chk("fl_discard_block", ms_allowin, 0);
        chk("fl_pend", pend_dest, 0);
        tick();
        tick();
        resp(64'hDEAD_BEEF_DEAD_BEEF);
        @(negedge clk);
        chk("fl_discard_clear", ms_allowin, 1);
        chk("fl_resp_err", resp_err, 0);
        chk("fl_still_empty", ms_to_ws_valid, 0);
        tick();
        ws_allowin = 1'b1;
        load_case(32'h404, LW, 64'h3000, 64'h0, 64'h0123_4567_89AB_CDEF,
                  64'hFFFF_FFFF_89AB_CDEF);
        drain();

        // Stray response while idle
        resp(64'h5555);
        @(negedge clk);
        chk("stray_resp_err", resp_err, 1);
        chk("stray_no_output", ms_to_ws_valid, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
